// File: rtl/add_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the nibble-serial adder sequencer:
//   - seqState_t : controller state encoding (IDLE, RUN, DONE)
//   - SLICE_W    : width of the single adder slice (4 bits)
//   - numSlices(): number of slices needed for a given operand width
//   - idxWidth() : width of the slice counter (at least 1 bit)
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    // Number of nibble slices that make up one operand.
    function automatic int numSlices(input int width);
        return width / SLICE_W;
    endfunction

    // Counter width for the slice index; a single-slice build still needs one bit.
    function automatic int idxWidth(input int width);
        int n;
        n = width / SLICE_W;
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_slice.sv
// ---------------------------------------------------------------------------
// add_seq_slice
// Purely combinational 4-bit ripple full-adder slice built from per-bit
// sum/carry logic.
// Ports:
//   i_a    [3:0]  slice operand A
//   i_b    [3:0]  slice operand B
//   i_cin         carry into bit 0
//   o_s    [3:0]  slice sum
//   o_cout        carry out of bit 3
// ---------------------------------------------------------------------------
module add_seq_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = i_cin;

    // Classic ripple chain: each bit generates when both inputs are set and
    // propagates the incoming carry when exactly one input is set.
    for (genvar k = 0; k < SLICE_W; k++) begin : g_bit
        assign o_s[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
        assign w_c[k+1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
    end

    assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add_seq_ctrl
// Multi-cycle WIDTH-bit adder that reuses one 4-bit slice, one nibble per
// clock, LSB first. Operands arrive on a valid/ready handshake, the result
// leaves on a second valid/ready handshake.
// Optional feature macro: ADD_SEQ_SUB_EN (adds op_sub input for a-b).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair presented
//   in_ready   controller idle and able to accept operands
//   a, b       operands, sampled on the accept edge
//   op_sub     (ADD_SEQ_SUB_EN only) 1 = compute a-b
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   sum        result (modulo 2^WIDTH)
//   carry      carry out of the MSB slice (no-borrow flag when subtracting)
// ---------------------------------------------------------------------------
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NSLICE = numSlices(WIDTH);
    localparam int IDX_W  = idxWidth(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_badWidth
        $error("add_seq_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    seqState_t          r_state;
    seqState_t          w_nextState;
    logic [WIDTH-1:0]   r_aSh;
    logic [WIDTH-1:0]   r_bSh;
    logic [WIDTH-1:0]   r_sumSh;
    logic               r_cy;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_accept;
    logic               w_lastSlice;
    logic               w_subSel;
    logic [SLICE_W-1:0] w_sliceS;
    logic               w_sliceCout;
    logic [WIDTH+SLICE_W-1:0] w_sumCat;
    logic [WIDTH-1:0]   w_sumNext;

`ifdef ADD_SEQ_SUB_EN
    assign w_subSel = op_sub;
`else
    assign w_subSel = 1'b0;
`endif

    add_seq_slice u_slice (
        .i_a    (r_aSh[SLICE_W-1:0]),
        .i_b    (r_bSh[SLICE_W-1:0]),
        .i_cin  (r_cy),
        .o_s    (w_sliceS),
        .o_cout (w_sliceCout)
    );

    // New nibbles enter at the top so that after NSLICE steps the first
    // nibble computed has slid down to bit 0.
    assign w_sumCat  = {w_sliceS, r_sumSh};
    assign w_sumNext = w_sumCat[WIDTH+SLICE_W-1:SLICE_W];

    // in_ready is gated by rst so nothing can be handed over while reset is held.
    assign in_ready = (r_state == IDLE) && !rst;
    assign sum      = r_sum;
    assign carry    = r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_lastSlice = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_lastSlice = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    // The visible sum/carry are only updated on the final slice, so they
    // always show the last completed result and never a partial one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_sumSh <= '0;
            r_cy    <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_aSh <= a;
            r_bSh <= w_subSel ? ~b : b;
            r_cy  <= w_subSel;
            r_idx <= '0;
        end else if (r_state == RUN) begin
            r_aSh   <= r_aSh >> SLICE_W;
            r_bSh   <= r_bSh >> SLICE_W;
            r_sumSh <= w_sumNext;
            r_cy    <= w_sliceCout;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_lastSlice) begin
                r_sum   <= w_sumNext;
                r_carry <= w_sliceCout;
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_seq_ctrl
// Self-checking bench for add_seq_ctrl (WIDTH=16). Expected results come from
// plain integer arithmetic on the operands. Honors ADD_SEQ_SUB_EN.
// ---------------------------------------------------------------------------
module tb_add_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSub;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] sumOut;
    logic             carryOut;

    int compareCount  = 0;
    int mismatchCount = 0;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
`ifdef ADD_SEQ_SUB_EN
        .op_sub    (opSub),
`endif
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .carry     (carryOut)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result: {carry, sum} as the true (WIDTH+1)-bit arithmetic value.
    function automatic logic [WIDTH:0] modelResult(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input bit sub);
        int unsigned xi;
        int unsigned yi;
        xi = int'(x);
        yi = int'(y);
        if (sub) begin
            // a - b + 2^WIDTH: bit WIDTH is set exactly when a >= b.
            return (WIDTH+1)'(xi + (32'd1 << WIDTH) - yi);
        end
        return (WIDTH+1)'(xi + yi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: wait for ready, hand over operands, measure latency,
    // check the result, optionally hold backpressure for 'stall' cycles while
    // poking in_valid with junk, then consume and check return to idle.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input bit sub,
                                 input int stall);
        logic [WIDTH:0] exp;
        int             lat;
        int             waitCnt;
        exp     = modelResult(x, y, sub);
        waitCnt = 0;
        while (!inReady && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, ".ready"}, 32'(inReady), 32'd1);
        opA      = x;
        opB      = y;
        opSub    = sub;
        inValid  = 1'b1;
        outReady = 1'b0;
        tick();
        inValid = 1'b0;
        opA     = WIDTH'($urandom);
        opB     = WIDTH'($urandom);
        opSub   = 1'($urandom);
        lat     = 0;
        while (!outValid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(NSLICE));
        checkOutput({tag, ".sum"}, 32'(sumOut), 32'(exp[WIDTH-1:0]));
        checkOutput({tag, ".carry"}, 32'(carryOut), 32'(exp[WIDTH]));
        for (int i = 0; i < stall; i++) begin
            inValid = 1'b1;
            opA     = WIDTH'($urandom);
            opB     = WIDTH'($urandom);
            checkOutput({tag, ".stallReady"}, 32'(inReady), 32'd0);
            tick();
            inValid = 1'b0;
            checkOutput({tag, ".stallValid"}, 32'(outValid), 32'd1);
            checkOutput({tag, ".stallSum"}, {15'd0, carryOut, sumOut}, 32'(exp));
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput({tag, ".drained"}, {30'd0, outValid, inReady}, 32'b01);
    endtask

    logic [WIDTH-1:0] pairA[3];
    logic [WIDTH-1:0] pairB[3];
    logic [WIDTH:0]   expQ[$];
    logic [WIDTH:0]   expNow;

    initial begin
        int sent;
        int got;
        int lastCycle;
        int cyc;
        int validSeen;
        bit acc;
        bit sub;

        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        opA      = '0;
        opB      = '0;
        opSub    = 1'b0;
        #12;
        checkOutput("reset.outputs", {30'd0, outValid, carryOut}, 32'd0);
        checkOutput("reset.sum", 32'(sumOut), 32'd0);
        checkOutput("reset.inReady", 32'(inReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("reset.release", 32'(inReady), 32'd1);

        // Directed cases
        applyStimulus("basic", 16'h1234, 16'h4321, 1'b0, 0);
        applyStimulus("ripple", 16'hFFFF, 16'h0001, 1'b0, 0);
        applyStimulus("ripple2", 16'h0F0F, 16'h00F1, 1'b0, 0);
        applyStimulus("backpr", 16'hBEEF, 16'h1111, 1'b0, 6);

        // Reset in the middle of a run
        opA     = 16'hAAAA;
        opB     = 16'h5555;
        opSub   = 1'b0;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst.outputs", {15'd0, outValid, carryOut, sumOut}, 32'd0);
        checkOutput("midrst.inReady", 32'(inReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (outValid) validSeen++;
        end
        checkOutput("midrst.noValid", 32'(validSeen), 32'd0);
        applyStimulus("postrst", 16'h0001, 16'h0002, 1'b0, 0);

`ifdef ADD_SEQ_SUB_EN
        applyStimulus("sub7m5", 16'h0007, 16'h0005, 1'b1, 0);
        applyStimulus("sub5m7", 16'h0005, 16'h0007, 1'b1, 1);
`endif

        // Randomized transactions
        for (int n = 0; n < 12; n++) begin
            sub = 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub = 1'($urandom);
`endif
            applyStimulus("rand", WIDTH'($urandom), WIDTH'($urandom), sub,
                          int'($urandom_range(0, 3)));
        end

        // Back-to-back with in_valid and out_ready held high
        pairA[0] = 16'h1111; pairB[0] = 16'h2222;
        pairA[1] = 16'hF00F; pairB[1] = 16'h0FF1;
        pairA[2] = WIDTH'($urandom); pairB[2] = WIDTH'($urandom);
        sent      = 0;
        got       = 0;
        lastCycle = 0;
        cyc       = 0;
        outReady  = 1'b1;
        opSub     = 1'b0;
        while (got < 3 && cyc < 60) begin
            if (sent < 3) begin
                opA     = pairA[sent];
                opB     = pairB[sent];
                inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            acc = inReady && inValid;
            tick();
            cyc++;
            if (acc) begin
                expQ.push_back(modelResult(pairA[sent], pairB[sent], 1'b0));
                sent++;
            end
            if (outValid) begin
                if (expQ.size() > 0) begin
                    expNow = expQ.pop_front();
                    checkOutput("b2b.result", {15'd0, carryOut, sumOut}, 32'(expNow));
                end else begin
                    checkOutput("b2b.unexpected", 32'd1, 32'd0);
                end
                if (got > 0) begin
                    checkOutput("b2b.period", 32'(cyc - lastCycle), 32'(NSLICE + 2));
                end
                lastCycle = cyc;
                got++;
            end
        end
        checkOutput("b2b.count", 32'(got), 32'd3);
        inValid  = 1'b0;
        outReady = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit additions by driving a single 4-bit full-adder slice one nibble per clock, LSB first. The carry is held in a register between slices. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. It extends the team's 4-bit ripple adder to wider operands without replicating the adder hardware.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a/b presented
in_ready  output  1  controller can accept operands (IDLE only)
a  input  WIDTH  operand A, sampled on the accept edge
b  input  WIDTH  operand B, sampled on the accept edge
out_valid  output  1  sum/carry valid, held until consumed
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry  output  1  carry out of the MSB slice

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- NSLICE = WIDTH/4. Internal registers:
  - a_sh, b_sh: shift registers, shifted right 4 bits per RUN cycle.
  - sum_r: filled from the top, 4 bits per cycle.
  - cy_r: carry register.
  - idx: slice counter, width clog2(NSLICE), minimum 1.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready: capture a->a_sh, b->b_sh; cy_r<=0; idx<=0; go to RUN.
  - RUN: slice adder computes a_sh[3:0]+b_sh[3:0]+cy_r. Its nibble is written into sum_r and its cout into cy_r. idx++. When idx==NSLICE-1, go to DONE on that edge.
  - DONE: out_valid=1; sum=sum_r, carry=cy_r held stable. On out_ready, go to IDLE.
- Latency: accept at edge E. RUN occupies edges E+1..E+NSLICE. out_valid is high from after edge E+NSLICE (4 cycles for WIDTH=16).
- Throughput: with out_ready tied high, one result per NSLICE+2 cycles. There is no overlap of accept and drain.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and nothing is captured.
- Operands need not be held after the accept edge.
- Arithmetic is modulo 2^WIDTH; carry is bit WIDTH of the true sum.
- Reset values (asynchronous, any state including mid-RUN): state=IDLE, out_valid=0, sum=0, carry=0, idx=0, shift registers=0. in_ready is forced to 0 while rst is high and is 1 after release. A reset mid-operation aborts the operation; no partial result is ever presented.
- sum/carry change only on RUN edges. They are held between results and always equal the last completed result.

Optional Feature:
Macro ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), sampled on the accept edge into a register.
  - When op_sub=1: b_sh is loaded with ~b and cy_r initialises to 1, so the result is a-b modulo 2^WIDTH.
  - carry=1 means no borrow (a>=b unsigned).
- Not defined: the port is absent and the block always adds. Logic is identical to op_sub tied 0.

Decomposition:
- Package add_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the SLICE_W=4 constant;
  - the function computing NSLICE/idx width.
- One sub-module, add_seq_slice: purely combinational 4-bit full-adder slice (a, b, cin -> s, cout), built from per-bit carry/sum logic. It is instantiated once.

Test Plan:
- Basic add: WIDTH=16, a=0x1234, b=0x4321 -> sum=0x5555, carry=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1. Also a=0x0F0F, b=0x00F1 -> sum=0x1000, carry=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid. sum/carry stay stable, in_ready=0, and a pulsed in_valid with new operands is not captured. Result is consumed on the out_ready edge, then in_ready=1 next cycle.
- Reset mid-run: accept 0xAAAA+0x5555, assert rst after the 2nd RUN cycle. Outputs go to 0 immediately and out_valid never rises. Post-reset 0x0001+0x0002 gives 0x0003.
- Back-to-back: out_ready=1 and in_valid=1 continuously with 3 operand pairs. Results appear every 6 cycles, in order, all correct.
- ADD_SEQ_SUB_EN: op_sub=1, 0x0007-0x0005 -> 0x0002, carry=1. 0x0005-0x0007 -> 0xFFFE, carry=0.
